// File: rtl/total_accumulator_pkg.sv
// Shared types and constants for the decimal total accumulator.
// Holds the state encoding and the entry-width legality check.
package total_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        TOTAL,
        OVF
    } state_t;

    localparam int DIGIT_MAX = 9;

    // True when the largest MAX_DIGITS-digit decimal entry fits in WIDTH bits.
    function automatic bit entryFitsWidth(input int width, input int maxDigits);
        longint unsigned pow10;
        longint unsigned widthMax;
        pow10 = 1;
        for (int i = 0; i < maxDigits; i++) begin
            pow10 = pow10 * 10;
        end
        if (width >= 63) begin
            return 1'b1;
        end
        widthMax = (64'd1 << width) - 1;
        return (pow10 - 1) <= widthMax;
    endfunction

endpackage

// File: rtl/total_accumulator_cmd_edge_detect.sv
// Rising-edge detector for the controller command levels plus the error level.
// Commands are suppressed while errIn is high; the error edge itself is reported.
module cmd_edge_detect
    import total_accumulator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] levelIn,
    input  logic         errIn,
    output logic [N-1:0] cmdPulse,
    output logic         errRise
);

    logic [N-1:0] levelQ;
    logic         errQ;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            levelQ <= '0;
            errQ   <= 1'b0;
        end else begin
            levelQ <= levelIn;
            errQ   <= errIn;
        end
    end

    assign cmdPulse = levelIn & ~levelQ & {N{~errIn}};
    assign errRise  = errIn & ~errQ;

endmodule

// File: rtl/total_accumulator.sv
// Decimal calculator datapath driven by one-hot command levels from the button decoder.
// Builds entries digit by digit, accumulates a saturating sum and drives the display value.
module total_accumulator
    import total_accumulator_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enterIn,
    input  logic                 numberIn,
    input  logic                 totalIn,
    input  logic                 clearIn,
    input  logic                 errIn,
    input  logic [3:0]           digitIn,
    output logic [WIDTH-1:0]     displayValue,
    output logic                 showTotal,
    output logic                 overflow,
    output logic                 badDigit,
    output logic [2:0]           digitCount,
    output logic [ERR_CNT_W-1:0] errCount
);

    if (!entryFitsWidth(WIDTH, MAX_DIGITS)) begin : gBadParams
        $error("total_accumulator: MAX_DIGITS decimal digits do not fit in WIDTH bits");
    end

    logic [3:0] cmd;
    logic       errRise;

    cmd_edge_detect #(.N(4)) uEdge (
        .clk      (clk),
        .rst_n    (rst_n),
        .levelIn  ({clearIn, totalIn, enterIn, numberIn}),
        .errIn    (errIn),
        .cmdPulse (cmd),
        .errRise  (errRise)
    );

    state_t           state, stateNext, commitTarget;
    logic [WIDTH-1:0] entry, entryNext, sum, sumNext, displayNext;
    logic [2:0]       countNext;
    logic             badNext, commitReq;
    logic [WIDTH:0]   commitSum;
    logic [WIDTH-1:0] appended;

    // One extra bit on the sum so the carry out flags overflow in the commit cycle.
    assign commitSum = {1'b0, sum} + {1'b0, entry};
    assign appended  = (entry << 3) + (entry << 1) + WIDTH'(digitIn);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        stateNext    = state;
        entryNext    = entry;
        sumNext      = sum;
        countNext    = digitCount;
        badNext      = 1'b0;
        commitReq    = 1'b0;
        commitTarget = IDLE;

        if (cmd[3]) begin
            stateNext = IDLE;
            entryNext = '0;
            sumNext   = '0;
            countNext = '0;
        end else if (cmd[2]) begin
            case (state)
                IDLE, TOTAL: stateNext = TOTAL;
                ENTRY: begin
                    commitReq    = 1'b1;
                    commitTarget = TOTAL;
                end
                default: ;
            endcase
        end else if (cmd[1]) begin
            case (state)
                ENTRY: begin
                    commitReq    = 1'b1;
                    commitTarget = IDLE;
                end
                TOTAL:   stateNext = IDLE;
                default: ;
            endcase
        end else if (cmd[0]) begin
            if (digitIn > 4'(DIGIT_MAX)) begin
                badNext = 1'b1;
            end else begin
                case (state)
                    IDLE, TOTAL: begin
                        stateNext = ENTRY;
                        entryNext = WIDTH'(digitIn);
                        countNext = 3'd1;
                    end
                    ENTRY: begin
                        if (digitCount < 3'(MAX_DIGITS)) begin
                            entryNext = appended;
                            countNext = digitCount + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (commitReq) begin
            entryNext = '0;
            countNext = '0;
            if (commitSum[WIDTH]) begin
                stateNext = OVF;
                sumNext   = '1;
            end else begin
                stateNext = commitTarget;
                sumNext   = commitSum[WIDTH-1:0];
            end
        end

        case (stateNext)
            TOTAL:   displayNext = sumNext;
            OVF:     displayNext = '1;
            default: displayNext = entryNext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            entry        <= '0;
            sum          <= '0;
            digitCount   <= '0;
            displayValue <= '0;
            showTotal    <= 1'b0;
            overflow     <= 1'b0;
            badDigit     <= 1'b0;
            errCount     <= '0;
        end else begin
            state        <= stateNext;
            entry        <= entryNext;
            sum          <= sumNext;
            digitCount   <= countNext;
            displayValue <= displayNext;
            showTotal    <= (stateNext == TOTAL);
            overflow     <= (stateNext == OVF);
            badDigit     <= badNext;
            if (errRise && (errCount != '1)) begin
                errCount <= errCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_total_accumulator.sv
// Self-checking bench for total_accumulator: directed scenarios plus a randomized run
// compared against an arithmetic model of the calculator rules.
module tb_total_accumulator;

    localparam int WIDTH      = 16;
    localparam int MAX_DIGITS = 4;
    localparam int ERR_CNT_W  = 8;
    localparam int SUM_MAX    = (1 << WIDTH) - 1;
    localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;

    localparam bit [3:0] NONE = 4'b0000;
    localparam bit [3:0] NUM  = 4'b0001;
    localparam bit [3:0] ENT  = 4'b0010;
    localparam bit [3:0] TOT  = 4'b0100;
    localparam bit [3:0] CLR  = 4'b1000;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_TOTAL = 2;
    localparam int M_OVF   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enterIn, numberIn, totalIn, clearIn, errIn;
    logic [3:0]           digitIn;
    logic [WIDTH-1:0]     displayValue;
    logic                 showTotal, overflow, badDigit;
    logic [2:0]           digitCount;
    logic [ERR_CNT_W-1:0] errCount;

    int total = 0;
    int bad   = 0;

    int     mState, mEntry, mSum, mCount, mErrCnt;
    bit     mBad, mPrevErr;
    bit [3:0] mPrev;

    total_accumulator #(
        .WIDTH      (WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enterIn      (enterIn),
        .numberIn     (numberIn),
        .totalIn      (totalIn),
        .clearIn      (clearIn),
        .errIn        (errIn),
        .digitIn      (digitIn),
        .displayValue (displayValue),
        .showTotal    (showTotal),
        .overflow     (overflow),
        .badDigit     (badDigit),
        .digitCount   (digitCount),
        .errCount     (errCount)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int expDisplay();
        if (mState == M_OVF)   return SUM_MAX;
        if (mState == M_TOTAL) return mSum;
        return mEntry;
    endfunction

    task automatic modelReset();
        mState = M_IDLE; mEntry = 0; mSum = 0; mCount = 0; mErrCnt = 0;
        mBad = 0; mPrev = '0; mPrevErr = 0;
    endtask

    task automatic modelCommit(input int target);
        int s;
        s = mSum + mEntry;
        mEntry = 0;
        mCount = 0;
        if (s > SUM_MAX) begin
            mState = M_OVF;
            mSum   = SUM_MAX;
        end else begin
            mSum   = s;
            mState = target;
        end
    endtask

    task automatic modelStep(input bit [3:0] lv, input bit err, input int d);
        bit [3:0] e;
        bit       eRise;
        e     = lv & ~mPrev & {4{~err}};
        eRise = err & ~mPrevErr;
        mPrev    = lv;
        mPrevErr = err;
        if (eRise && mErrCnt < ERR_MAX) mErrCnt++;
        mBad = 0;
        if (e[3]) begin
            mState = M_IDLE; mEntry = 0; mSum = 0; mCount = 0;
        end else if (e[2]) begin
            if (mState == M_ENTRY) modelCommit(M_TOTAL);
            else if (mState != M_OVF) mState = M_TOTAL;
        end else if (e[1]) begin
            if (mState == M_ENTRY) modelCommit(M_IDLE);
            else if (mState == M_TOTAL) mState = M_IDLE;
        end else if (e[0]) begin
            if (d > 9) mBad = 1;
            else if (mState == M_IDLE || mState == M_TOTAL) begin
                mState = M_ENTRY; mEntry = d; mCount = 1;
            end else if (mState == M_ENTRY && mCount < MAX_DIGITS) begin
                mEntry = mEntry * 10 + d;
                mCount++;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input bit [3:0] lv, input bit err, input int d);
        @(negedge clk);
        numberIn = lv[0]; enterIn = lv[1]; totalIn = lv[2]; clearIn = lv[3];
        errIn = err; digitIn = 4'(d);
        @(posedge clk);
        modelStep(lv, err, d);
        #1;
    endtask

    task automatic press(input bit [3:0] lv, input int d);
        step(lv, 1'b0, d);
        step(NONE, 1'b0, d);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        enterIn = 0; numberIn = 0; totalIn = 0; clearIn = 0; errIn = 0; digitIn = '0;
        modelReset();
        #23;
        total++; if (displayValue !== '0) begin bad++; $display("FAIL reset_disp got=%0d want=0", displayValue); end
        total++; if (showTotal !== 1'b0) begin bad++; $display("FAIL reset_showTotal got=%b want=0", showTotal); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (badDigit !== 1'b0) begin bad++; $display("FAIL reset_badDigit got=%b want=0", badDigit); end
        total++; if (digitCount !== 3'd0) begin bad++; $display("FAIL reset_digitCount got=%0d want=0", digitCount); end
        total++; if (errCount !== '0) begin bad++; $display("FAIL reset_errCount got=%0d want=0", errCount); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int digs[3] = '{1, 2, 3};
        int want[3] = '{1, 12, 123};
        for (int i = 0; i < 3; i++) begin
            press(NUM, digs[i]);
            total++; if (displayValue !== 16'(want[i])) begin bad++; $display("FAIL basic_digit%0d got=%0d want=%0d", i, displayValue, want[i]); end
            total++; if (digitCount !== 3'(i + 1)) begin bad++; $display("FAIL basic_count%0d got=%0d want=%0d", i, digitCount, i + 1); end
        end
        press(ENT, 0);
        total++; if (displayValue !== 16'd0) begin bad++; $display("FAIL basic_enter got=%0d want=0", displayValue); end
        press(TOT, 0);
        total++; if (displayValue !== 16'd123) begin bad++; $display("FAIL basic_total got=%0d want=123", displayValue); end
        total++; if (showTotal !== 1'b1) begin bad++; $display("FAIL basic_showTotal got=%b want=1", showTotal); end
    endtask

    task automatic test_hold();
        press(CLR, 0);
        for (int i = 0; i < 10; i++) begin
            step(NUM, 1'b0, 7);
            total++; if (displayValue !== 16'(expDisplay())) begin bad++; $display("FAIL hold_cycle%0d got=%0d want=%0d", i, displayValue, expDisplay()); end
        end
        step(NONE, 1'b0, 7);
        total++; if (displayValue !== 16'd7) begin bad++; $display("FAIL hold_entry got=%0d want=7", displayValue); end
        total++; if (digitCount !== 3'd1) begin bad++; $display("FAIL hold_count got=%0d want=1", digitCount); end
    endtask

    task automatic test_max_digits();
        press(CLR, 0);
        for (int i = 0; i < 5; i++) press(NUM, 9);
        total++; if (displayValue !== 16'd9999) begin bad++; $display("FAIL maxdig_entry got=%0d want=9999", displayValue); end
        total++; if (digitCount !== 3'd4) begin bad++; $display("FAIL maxdig_count got=%0d want=4", digitCount); end
    endtask

    task automatic test_overflow();
        press(CLR, 0);
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 4; i++) press(NUM, 9);
            press(ENT, 0);
            total++; if (overflow !== (k == 6)) begin bad++; $display("FAIL ovf_flag_iter%0d got=%b want=%b", k, overflow, k == 6); end
        end
        total++; if (displayValue !== 16'hFFFF) begin bad++; $display("FAIL ovf_disp got=%h want=ffff", displayValue); end
        press(NUM, 3);
        total++; if (displayValue !== 16'hFFFF) begin bad++; $display("FAIL ovf_num_ignored got=%h want=ffff", displayValue); end
        total++; if (digitCount !== 3'd0) begin bad++; $display("FAIL ovf_count got=%0d want=0", digitCount); end
        press(CLR, 0);
        total++; if (displayValue !== 16'd0) begin bad++; $display("FAIL ovf_clear_disp got=%0d want=0", displayValue); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_flag got=%b want=0", overflow); end
    endtask

    task automatic test_err();
        press(CLR, 0);
        step(NUM, 1'b1, 5);
        total++; if (displayValue !== 16'd0) begin bad++; $display("FAIL err_suppress got=%0d want=0", displayValue); end
        total++; if (errCount !== 8'd1) begin bad++; $display("FAIL err_count got=%0d want=1", errCount); end
        step(NUM, 1'b0, 5);
        total++; if (displayValue !== 16'd0) begin bad++; $display("FAIL err_not_deferred got=%0d want=0", displayValue); end
        step(NONE, 1'b0, 5);
        step(NUM, 1'b0, 12);
        total++; if (badDigit !== 1'b1) begin bad++; $display("FAIL baddig_pulse got=%b want=1", badDigit); end
        total++; if (displayValue !== 16'd0) begin bad++; $display("FAIL baddig_entry got=%0d want=0", displayValue); end
        step(NONE, 1'b0, 12);
        total++; if (badDigit !== 1'b0) begin bad++; $display("FAIL baddig_oneshot got=%b want=0", badDigit); end
    endtask

    task automatic test_reset_mid();
        press(CLR, 0);
        press(NUM, 4);
        press(NUM, 5);
        total++; if (displayValue !== 16'd45) begin bad++; $display("FAIL rmid_entry got=%0d want=45", displayValue); end
        @(negedge clk);
        clearIn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        total++; if (displayValue !== '0) begin bad++; $display("FAIL rmid_disp got=%0d want=0", displayValue); end
        total++; if (digitCount !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", digitCount); end
        total++; if (errCount !== '0) begin bad++; $display("FAIL rmid_errCount got=%0d want=0", errCount); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        modelStep(CLR, 1'b0, 0);
        #1;
        total++; if (displayValue !== '0) begin bad++; $display("FAIL rmid_release_disp got=%0d want=0", displayValue); end
        total++; if (showTotal !== 1'b0) begin bad++; $display("FAIL rmid_release_idle got=%b want=0", showTotal); end
        step(NONE, 1'b0, 0);
        press(NUM, 8);
        total++; if (displayValue !== 16'd8) begin bad++; $display("FAIL rmid_after got=%0d want=8", displayValue); end
    endtask

    task automatic test_err_sat();
        for (int i = 0; i < ERR_MAX + 5; i++) begin
            step(NONE, 1'b1, 0);
            step(NONE, 1'b0, 0);
        end
        total++; if (errCount !== ERR_CNT_W'(mErrCnt)) begin bad++; $display("FAIL errsat_model got=%0d want=%0d", errCount, mErrCnt); end
        total++; if (errCount !== ERR_CNT_W'(ERR_MAX)) begin bad++; $display("FAIL errsat_max got=%0d want=%0d", errCount, ERR_MAX); end
    endtask

    task automatic test_random();
        bit [3:0] lv;
        bit       err;
        int       d;
        press(CLR, 0);
        for (int i = 0; i < 600; i++) begin
            lv[0] = ($urandom_range(0, 99) < 40);
            lv[1] = ($urandom_range(0, 99) < 10);
            lv[2] = ($urandom_range(0, 99) < 8);
            lv[3] = ($urandom_range(0, 99) < 3);
            err   = ($urandom_range(0, 99) < 5);
            d     = $urandom_range(0, 11);
            step(lv, err, d);
            total++; if (displayValue !== 16'(expDisplay())) begin bad++; $display("FAIL rand_disp cyc=%0d got=%0d want=%0d", i, displayValue, expDisplay()); end
            total++; if (showTotal !== (mState == M_TOTAL)) begin bad++; $display("FAIL rand_showTotal cyc=%0d got=%b want=%b", i, showTotal, mState == M_TOTAL); end
            total++; if (overflow !== (mState == M_OVF)) begin bad++; $display("FAIL rand_overflow cyc=%0d got=%b want=%b", i, overflow, mState == M_OVF); end
            total++; if (badDigit !== mBad) begin bad++; $display("FAIL rand_badDigit cyc=%0d got=%b want=%b", i, badDigit, mBad); end
            total++; if (digitCount !== 3'(mCount)) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", i, digitCount, mCount); end
            total++; if (errCount !== ERR_CNT_W'(mErrCnt)) begin bad++; $display("FAIL rand_errCount cyc=%0d got=%0d want=%0d", i, errCount, mErrCnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_max_digits();
        test_overflow();
        test_err();
        test_reset_mid();
        test_err_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/total_accumulator.md
Name: total_accumulator

Overview:
- Downstream consumer of the button-decode controller's registered one-hot command levels (enter/number/total/clear) and its err flag.
- Turns each new command into one action on a decimal calculator datapath:
  - number appends the current digit to the entry.
  - enter adds the entry to a running sum.
  - total commits any pending entry and shows the sum.
  - clear zeroes everything.
- Drives the display value and status flags toward the display stage.

Parameters:
- WIDTH, 16, width of entry, sum and display value.
- MAX_DIGITS, 4, maximum decimal digits per entry. Elaboration check: 10^MAX_DIGITS-1 <= 2^WIDTH-1.
- ERR_CNT_W, 8, width of the saturating error-event counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enterIn  in  1  enter command level from controller.
- numberIn  in  1  number command level from controller.
- totalIn  in  1  total command level from controller.
- clearIn  in  1  clear command level from controller.
- errIn  in  1  controller multi-press error level.
- digitIn  in  4  BCD digit, sampled on a number command.
- displayValue  out  WIDTH  entry, sum or all-ones depending on state.
- showTotal  out  1  high while in TOTAL state.
- overflow  out  1  high while in OVF state.
- badDigit  out  1  one-cycle pulse when a number command carries digitIn > 9.
- digitCount  out  3  digits held in the current entry (0..MAX_DIGITS).
- errCount  out  ERR_CNT_W  count of errIn rising edges, saturating.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; entry=0; sum=0; all edge-detect history regs=0.
  - displayValue=0, showTotal=0, overflow=0, badDigit=0, digitCount=0, errCount=0.
- Edge detect:
  - cmdX = XIn & ~XIn_q & ~errIn; X_q registered every cycle.
  - A level held for many cycles acts once.
  - While errIn=1 all commands are suppressed. A command whose rising edge coincides with errIn=1 is lost, not deferred.
- Priority if several edges occur in one cycle (not expected): clear > total > enter > number.
- Number with digitIn > 9: no state change; badDigit=1 for exactly the next cycle.
- States:
  - IDLE:
    - number(d) -> ENTRY, entry=d, digitCount=1.
    - enter -> no-op.
    - total -> TOTAL.
  - ENTRY:
    - number(d) -> if digitCount<MAX_DIGITS, entry=entry*10+d and digitCount++; else ignored (stay).
    - enter -> sum=sum+entry, entry=0, digitCount=0, -> IDLE.
    - total -> same commit, -> TOTAL.
  - TOTAL:
    - number(d) -> ENTRY with entry=d.
    - enter -> IDLE.
    - total -> stay.
  - OVF: only clear leaves. number, enter and total are ignored.
  - clear, from any state -> IDLE, entry=0, sum=0, digitCount=0. errCount is unaffected.
- Arithmetic:
  - The sum is computed WIDTH+1 bits wide.
  - Carry out -> OVF, sum saturates to 2^WIDTH-1, entry=0.
  - Commit and overflow detection happen in the same cycle.
- displayValue, registered:
  - entry in IDLE and ENTRY; sum in TOTAL; all-ones in OVF.
  - showTotal = (state==TOTAL); overflow = (state==OVF).
- Latency: a command level first high in cycle N updates state and all outputs at the clk edge ending cycle N, so they are visible in cycle N+1.
- errCount: increments on each errIn rising edge, saturates at 2^ERR_CNT_W-1; only reset clears it.
- Reset asserted mid-entry or in OVF: immediate return to reset values. The first command after deassert needs a fresh rising edge, since history regs are 0 so a level still high counts as an edge.

Decomposition:
- Shared package:
  - state enum {IDLE, ENTRY, TOTAL, OVF}.
  - Constant DIGIT_MAX=9.
  - Function computing the WIDTH/MAX_DIGITS legality check.
- One natural sub-module: cmd_edge_detect. It holds the per-input history register and produces single-cycle cmd pulses gated by errIn. It is instantiated once, vectorised over the 4 commands plus errIn.

Test Plan:
- After reset, number with digitIn=1,2,3 (separate presses), then enter, then total -> displayValue 1, 12, 123, then 0 after enter, then 123 with showTotal=1.
- Hold numberIn high 10 cycles with digitIn=7 -> entry=7, digitCount=1 (single action).
- With MAX_DIGITS=4, press number 5 times with digitIn=9 -> entry=9999, fifth press ignored, digitCount=4.
- With WIDTH=16: enter 9999 seven times -> sum 69993 exceeds 65535, so OVF, displayValue=16'hFFFF, overflow=1. A following number press is ignored. clear -> IDLE, displayValue=0.
- numberIn edge while errIn=1 -> no entry change; errCount=1. digitIn=12 on a clean number press -> badDigit pulses 1 cycle, entry unchanged.
- Assert rst_n low mid-entry (entry=45) -> all outputs 0 asynchronously. Release with clearIn still high -> treated as a clear edge, state stays IDLE.
